downcounter_sync_load: RTL and testbench

//  Synchronous, loadable, parameterised down counter / interval timer. Complements the

---
 rtl/downcounter_sync_load.sv | 125 ++++++++++++
 tb/tb_downcounter_sync_load.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/downcounter_sync_load.sv
// Loadable down counter / interval timer: counts a programmed value down to zero,
// pulses a terminal-count flag and optionally reloads itself to run periodically.
module downcounter_sync_load #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_start,
  input  logic             i_stop,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_tc,
  output logic             o_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_next;
  logic             r_tc;
  logic             w_tc_next;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_count  <= ZERO;
      r_reload <= ZERO;
      r_tc     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_reload <= w_reload_next;
      r_tc     <= w_tc_next;
      // Status flags are registered from the next state so they track r_state exactly.
      r_busy   <= (w_state_next == ST_RUN);
      r_done   <= (w_state_next == ST_DONE);
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_reload_next = r_reload;
    w_tc_next     = 1'b0;

    if (i_load) begin
      w_count_next  = i_load_val;
      w_reload_next = i_load_val;
      w_state_next  = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!i_stop && i_start) begin
            if (r_count != ZERO) begin
              w_state_next = ST_RUN;
            end else begin
              w_state_next = ST_DONE;
              w_tc_next    = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (i_stop) begin
            w_state_next = ST_IDLE;
          end else if (r_count > ONE) begin
            w_count_next = r_count - ONE;
          end else if (r_count == ONE) begin
            w_count_next = ZERO;
            w_tc_next    = 1'b1;
            if (!AUTO_RELOAD) begin
              w_state_next = ST_DONE;
            end
          end else begin
            // Zero while running only happens in auto-reload mode: the reload edge
            // takes the place of a decrement, giving a period of reload+1 cycles.
            if (AUTO_RELOAD) begin
              w_count_next = r_reload;
            end else begin
              w_state_next = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (i_stop) begin
            w_state_next = ST_IDLE;
          end else if (i_start) begin
            if (r_reload != ZERO) begin
              w_count_next = r_reload;
              w_state_next = ST_RUN;
            end else begin
              w_tc_next = 1'b1;
            end
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign o_count = r_count;
  assign o_busy  = r_busy;
  assign o_tc    = r_tc;
  assign o_done  = r_done;

endmodule

// File: tb/tb_downcounter_sync_load.sv
// Scoreboard bench: two counters (one-shot and auto-reload) driven by directed
// vectors; expected outputs are queued by the stimulus and checked by a monitor.
module tb_downcounter_sync_load;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load0 = 1'b0, start0 = 1'b0, stop0 = 1'b0;
  logic [3:0] val0 = 4'd0;
  logic       load1 = 1'b0, start1 = 1'b0, stop1 = 1'b0;
  logic [3:0] val1 = 4'd0;
  logic [3:0] count0, count1;
  logic       busy0, tc0, done0;
  logic       busy1, tc1, done1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         sel;
    logic [3:0] cnt;
    logic       busy;
    logic       tc;
    logic       done;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  downcounter_sync_load #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_dut0 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (load0),
    .i_load_val (val0),
    .i_start    (start0),
    .i_stop     (stop0),
    .o_count    (count0),
    .o_busy     (busy0),
    .o_tc       (tc0),
    .o_done     (done0)
  );

  downcounter_sync_load #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u_dut1 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (load1),
    .i_load_val (val1),
    .i_start    (start1),
    .i_stop     (stop1),
    .o_count    (count1),
    .o_busy     (busy1),
    .o_tc       (tc1),
    .o_done     (done1)
  );

  // Monitor: the outputs settle after every clock edge and after an async reset.
  always begin
    exp_t       e;
    string      n;
    logic [6:0] act;
    logic [6:0] req;
    @(posedge clk or negedge rst_n);
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      act = (e.sel == 1) ? {count1, busy1, tc1, done1} : {count0, busy0, tc0, done0};
      req = {e.cnt, e.busy, e.tc, e.done};
      checks++;
      if (act !== req) begin
        failures++;
        $display("FAIL %s dut%0d: got count=%0d busy=%b tc=%b done=%b, expected count=%0d busy=%b tc=%b done=%b",
                 n, e.sel, act[6:3], act[2], act[1], act[0], req[6:3], req[2], req[1], req[0]);
      end else begin
        $display("check %s dut%0d ok: count=%0d busy=%b tc=%b done=%b",
                 n, e.sel, act[6:3], act[2], act[1], act[0]);
      end
    end
  end

  task automatic push_exp(input int sel, input logic [3:0] c, input logic b,
                          input logic t, input logic d, input string name);
    exp_t e;
    e.sel  = sel;
    e.cnt  = c;
    e.busy = b;
    e.tc   = t;
    e.done = d;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // One clock cycle: drive controls on the falling edge, queue the state expected
  // after the following rising edge.
  task automatic cyc(input int sel, input logic ld, input logic [3:0] v, input logic st,
                     input logic sp, input logic [3:0] c, input logic b, input logic t,
                     input logic d, input string name);
    @(negedge clk);
    load0 = 1'b0; val0 = 4'd0; start0 = 1'b0; stop0 = 1'b0;
    load1 = 1'b0; val1 = 4'd0; start1 = 1'b0; stop1 = 1'b0;
    if (sel == 1) begin
      load1 = ld; val1 = v; start1 = st; stop1 = sp;
    end else begin
      load0 = ld; val0 = v; start0 = st; stop0 = sp;
    end
    push_exp(sel, c, b, t, d, name);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, "reset_state0");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset_state1");

    // Basic count from 3
    cyc(0, 1, 3, 0, 0, 3, 0, 0, 0, "load3");
    cyc(0, 0, 0, 1, 0, 3, 1, 0, 0, "start3");
    cyc(0, 0, 0, 0, 0, 2, 1, 0, 0, "cnt2");
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 0, "cnt1");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, "tc3");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, "done_hold");
    // Restart from DONE reloads the stored value
    cyc(0, 0, 0, 1, 0, 3, 1, 0, 0, "done_restart");
    cyc(0, 0, 0, 0, 0, 2, 1, 0, 0, "re_cnt2");
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 0, "re_cnt1");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, "re_tc");
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, "done_stop");
    cyc(0, 0, 0, 1, 0, 0, 0, 1, 1, "idle_start_zero");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, "idle_start_zero_after");

    // Max value, no wrap
    cyc(0, 1, 15, 0, 0, 15, 0, 0, 0, "load15");
    cyc(0, 0, 0, 1, 0, 15, 1, 0, 0, "start15");
    for (int i = 14; i >= 1; i--) begin
      cyc(0, 0, 0, 0, 0, 4'(i), 1, 0, 0, "max_cnt");
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, "max_tc");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, "no_wrap_a");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, "no_wrap_b");

    // STOP and restart
    cyc(0, 1, 9, 0, 0, 9, 0, 0, 0, "load9");
    cyc(0, 0, 0, 1, 0, 9, 1, 0, 0, "start9");
    cyc(0, 0, 0, 0, 0, 8, 1, 0, 0, "s_cnt8");
    cyc(0, 0, 0, 0, 0, 7, 1, 0, 0, "s_cnt7");
    cyc(0, 0, 0, 0, 0, 6, 1, 0, 0, "s_cnt6");
    cyc(0, 0, 0, 0, 1, 6, 0, 0, 0, "stop_at6");
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 0, 6, 0, 0, 0, "stop_hold");
    end
    cyc(0, 0, 0, 1, 0, 6, 1, 0, 0, "resume");
    for (int i = 5; i >= 1; i--) begin
      cyc(0, 0, 0, 0, 0, 4'(i), 1, 0, 0, "resume_cnt");
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, "resume_tc");

    // Control priority
    cyc(0, 1, 9, 0, 0, 9, 0, 0, 0, "p_load9");
    cyc(0, 0, 0, 1, 0, 9, 1, 0, 0, "p_start");
    cyc(0, 0, 0, 0, 0, 8, 1, 0, 0, "p_cnt8");
    cyc(0, 1, 7, 1, 1, 7, 0, 0, 0, "priority_load");
    cyc(0, 0, 0, 0, 0, 7, 0, 0, 0, "priority_hold");
    cyc(0, 0, 0, 1, 0, 7, 1, 0, 0, "p_start7");
    cyc(0, 0, 0, 0, 0, 6, 1, 0, 0, "p_cnt6");
    cyc(0, 0, 0, 1, 1, 6, 0, 0, 0, "stop_over_start");
    // LOAD on the terminal edge suppresses TC
    cyc(0, 1, 2, 0, 0, 2, 0, 0, 0, "l_load2");
    cyc(0, 0, 0, 1, 0, 2, 1, 0, 0, "l_start");
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 0, "l_cnt1");
    cyc(0, 1, 5, 0, 0, 5, 0, 0, 0, "load_beats_tc");

    // Asynchronous reset mid-run at count 5
    cyc(0, 1, 6, 0, 0, 6, 0, 0, 0, "r_load6");
    cyc(0, 0, 0, 1, 0, 6, 1, 0, 0, "r_start");
    cyc(0, 0, 0, 0, 0, 5, 1, 0, 0, "r_cnt5");
    @(negedge clk);
    load0 = 1'b0; start0 = 1'b0; stop0 = 1'b0;
    #2;
    push_exp(0, 0, 0, 0, 0, "async_reset");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, "post_reset");
    // Reload register was cleared too: START from DONE keeps pulsing TC
    cyc(0, 0, 0, 1, 0, 0, 0, 1, 1, "post_reset_start");
    cyc(0, 0, 0, 1, 0, 0, 0, 1, 1, "reload_cleared");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, "reload_cleared_after");

    // Auto-reload: period of 3 cycles for LOAD 2
    cyc(1, 1, 2, 0, 0, 2, 0, 0, 0, "ar_load2");
    cyc(1, 0, 0, 1, 0, 2, 1, 0, 0, "ar_start");
    for (int p = 0; p < 3; p++) begin
      cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, "ar_cnt1");
      cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, "ar_tc");
      cyc(1, 0, 0, 0, 0, 2, 1, 0, 0, "ar_reload");
    end
    cyc(1, 0, 0, 0, 1, 2, 0, 0, 0, "ar_stop");
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, "ar_load0");
    cyc(1, 0, 0, 1, 0, 0, 0, 1, 1, "ar_zero_start");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, "ar_zero_done");

    @(negedge clk);
    load0 = 1'b0; start0 = 1'b0; stop0 = 1'b0;
    load1 = 1'b0; start1 = 1'b0; stop1 = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
